// File: rtl/sync_seq_pkg.sv
// Shared types and code-conversion helpers for the sequence counter.
// Helpers work on MAX_W-bit zero-extended values; callers size-cast the result.
package sync_seq_pkg;

  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'b00,
    MODE_GRAY = 2'b01,
    MODE_JOHN = 2'b10,
    MODE_RING = 2'b11
  } mode_e;

  function automatic logic [MAX_W-1:0] bin2gray(logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic is_onehot(logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

  // A Johnson code has at most one boundary between its run of ones and zeros.
  function automatic logic johnson_valid(logic [MAX_W-1:0] v, int w);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W-1; i++)
      if ((i < w-1) && (v[i] != v[i+1])) n++;
    return n <= 1;
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational successor and last-state detect for the selected code.
// Illegal codes recover to the mode's seed and never report last.
module seq_next_state
  import sync_seq_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode_q,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt_q,
  output logic             is_last
);

  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] HI_BIT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LO_BIT  = WIDTH'(1);

  logic             bin_over;
  logic [WIDTH-1:0] gray_bin;
  logic [WIDTH-1:0] gray_step;
  logic             john_ok;
  logic             ring_ok;

  assign bin_over  = {1'b0, q} >= MOD_EXT;
  assign gray_bin  = WIDTH'(gray2bin(MAX_W'(q)));
  assign gray_step = dir ? gray_bin + WIDTH'(1) : gray_bin - WIDTH'(1);
  assign john_ok   = johnson_valid(MAX_W'(q), WIDTH);
  assign ring_ok   = is_onehot(MAX_W'(q));

  always_comb begin
    nxt_q   = '0;
    is_last = 1'b0;
    case (mode_q)
      MODE_BIN: begin
        if (bin_over)  nxt_q = '0;
        else if (dir)  nxt_q = (q == MOD_MAX) ? '0 : q + WIDTH'(1);
        else           nxt_q = (q == '0) ? MOD_MAX : q - WIDTH'(1);
        is_last = !bin_over && (q == (dir ? MOD_MAX : '0));
      end
      MODE_GRAY: begin
        nxt_q   = WIDTH'(bin2gray(MAX_W'(gray_step)));
        is_last = (q == (dir ? HI_BIT : '0));
      end
      MODE_JOHN: begin
        if (!john_ok) nxt_q = '0;
        else if (dir) nxt_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
        else          nxt_q = {~q[0], q[WIDTH-1:1]};
        is_last = john_ok && (q == (dir ? HI_BIT : LO_BIT));
      end
      MODE_RING: begin
        if (!ring_ok) nxt_q = LO_BIT;
        else if (dir) nxt_q = {q[WIDTH-2:0], q[WIDTH-1]};
        else          nxt_q = {q[0], q[WIDTH-1:1]};
        is_last = ring_ok && (q == (dir ? HI_BIT : LO_BIT));
      end
      default: begin
        nxt_q   = '0;
        is_last = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sync_seq_counter.sv
// Runtime-selectable binary/Gray/Johnson/ring counter with load and terminal count.
// Top holds the state registers, the load > resync > count priority, and tc gating.
module sync_seq_counter
  import sync_seq_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("sync_seq_counter: WIDTH must be in 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("sync_seq_counter: MODULUS must be in 2..2**WIDTH");
  end

  mode_e            mode_in;
  mode_e            mode_q;
  logic             mode_chg;
  logic [WIDTH-1:0] nxt_q;
  logic [WIDTH-1:0] seed;
  logic             is_last;

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign seed     = (mode_in == MODE_RING) ? WIDTH'(1) : '0;

  seq_next_state #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q       (q),
    .mode_q  (mode_q),
    .dir     (dir),
    .nxt_q   (nxt_q),
    .is_last (is_last)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q      <= '0;
      mode_q <= MODE_BIN;
    end else if (load) begin
      q      <= load_val;
      mode_q <= mode_in;
    end else if (mode_chg) begin
      // Switching codes restarts from the new mode's seed; en is ignored.
      q      <= seed;
      mode_q <= mode_in;
    end else if (en) begin
      q      <= nxt_q;
    end
  end

  assign tc = en && !mode_chg && !load && is_last;

endmodule
